// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back data cache controller.
// Optional macro DCACHE_PERF_CNT_EN adds hit/miss performance counters.
module dcache_ctrl #(
  parameter int INDEX_WIDTH = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_req,
  input  logic         cpu_wr,
  input  logic [31:0]  cpu_addr,
  input  logic [31:0]  cpu_wdata,
  output logic         cpu_ready,
  output logic         cpu_resp_valid,
  output logic [31:0]  cpu_rdata,
  output logic         mem_rreq,
  output logic [31:0]  mem_raddr,
  input  logic         mem_rrdy,
  input  logic         mem_ret_valid,
  input  logic [31:0]  mem_ret_data,
  output logic         mem_wreq,
  output logic [31:0]  mem_waddr,
  output logic [127:0] mem_wdata,
  input  logic         mem_wrdy,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
);
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = 28 - INDEX_WIDTH;

  typedef enum logic [1:0] {
    IDLE, LOOKUP, WRITEBACK, REFILL
  } state_t;

  state_t state, state_n;

  logic [31:2]      addr_q;
  logic             wr_q;
  logic [31:0]      wdata_q;
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_arr [LINES];
  logic [127:0]     data_arr [LINES];
  logic [95:0]      beat_buf;
  logic [1:0]       beat_q;
  logic             req_done_q;
  logic [31:0]      rdata_q;

  logic [INDEX_WIDTH-1:0] idx;
  logic [TAG_W-1:0]       tag;
  logic [1:0]             word;
  logic [127:0]           line;
  logic [31:0]            hit_word;
  logic                   hit;
  logic                   lookup_hit;
  logic                   lookup_miss;
  logic                   beat_fire;
  logic                   last_beat;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];

  assign idx  = addr_q[INDEX_WIDTH+3:4];
  assign tag  = addr_q[31:INDEX_WIDTH+4];
  assign word = addr_q[3:2];
  assign line = data_arr[idx];
  assign hit_word = line[{word, 5'b0} +: 32];
  assign hit = valid_q[idx] && (tag_arr[idx] == tag);

  assign lookup_hit  = (state == LOOKUP) && hit;
  assign lookup_miss = (state == LOOKUP) && !hit;
  assign beat_fire   = (state == REFILL) && req_done_q
                    && mem_ret_valid;
  assign last_beat   = beat_fire && (beat_q == 2'd3);

  assign cpu_ready      = (state == IDLE);
  assign cpu_resp_valid = lookup_hit;
  assign cpu_rdata      = (lookup_hit && !wr_q) ? hit_word
                                                : rdata_q;

  assign mem_rreq  = (state == REFILL) && !req_done_q;
  assign mem_raddr = {addr_q[31:4], 4'b0};
  assign mem_wreq  = (state == WRITEBACK);
  assign mem_waddr = {tag_arr[idx], idx, 4'b0};
  assign mem_wdata = line;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (cpu_req) state_n = LOOKUP;
      LOOKUP: begin
        if (hit)
          state_n = IDLE;
        else if (valid_q[idx] && dirty_q[idx])
          state_n = WRITEBACK;
        else
          state_n = REFILL;
      end
      WRITEBACK: if (mem_wrdy) state_n = REFILL;
      REFILL:    if (last_beat) state_n = LOOKUP;
      default:   state_n = IDLE;
    endcase
  end

  // Request latch, line status bits, refill sequencing, load data hold
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      beat_q     <= '0;
      req_done_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (state == IDLE && cpu_req) begin
        addr_q  <= cpu_addr[31:2];
        wr_q    <= cpu_wr;
        wdata_q <= cpu_wdata;
      end
      if (state != REFILL && state_n == REFILL) begin
        beat_q     <= '0;
        req_done_q <= 1'b0;
      end
      if (state == REFILL && !req_done_q && mem_rrdy)
        req_done_q <= 1'b1;
      if (beat_fire)
        beat_q <= beat_q + 2'd1;
      if (last_beat) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
      if (lookup_hit) begin
        if (wr_q) dirty_q[idx] <= 1'b1;
        else      rdata_q      <= hit_word;
      end
    end
  end

  // Tag/data storage: refill install and store-hit word merge
  always_ff @(posedge clk) begin
    if (beat_fire)
      beat_buf <= {mem_ret_data, beat_buf[95:32]};
    if (last_beat) begin
      tag_arr[idx]  <= tag;
      data_arr[idx] <= {mem_ret_data, beat_buf};
    end else if (lookup_hit && wr_q) begin
      data_arr[idx][{word, 5'b0} +: 32] <= wdata_q;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;
  logic        replay_q;

  // Count first-pass hits and misses; a post-refill replay is not a hit
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q    <= '0;
      miss_q   <= '0;
      replay_q <= 1'b0;
    end else begin
      if (state == IDLE && cpu_req) replay_q <= 1'b0;
      if (last_beat)                replay_q <= 1'b1;
      if (lookup_hit && !replay_q)  hit_q    <= hit_q + 32'd1;
      if (lookup_miss)              miss_q   <= miss_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl.
// Memory responder plus reference memory view predict all results.
module tb_dcache_ctrl;
  logic         clk;
  logic         rst;
  logic         cpu_req;
  logic         cpu_wr;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_ready;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_rdata;
  logic         mem_rreq;
  logic [31:0]  mem_raddr;
  logic         mem_rrdy;
  logic         mem_ret_valid;
  logic [31:0]  mem_ret_data;
  logic         mem_wreq;
  logic [31:0]  mem_waddr;
  logic [127:0] mem_wdata;
  logic         mem_wrdy;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  dcache_ctrl #(.INDEX_WIDTH(6)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready),
    .cpu_resp_valid(cpu_resp_valid),
    .cpu_rdata(cpu_rdata),
    .mem_rreq(mem_rreq), .mem_raddr(mem_raddr),
    .mem_rrdy(mem_rrdy),
    .mem_ret_valid(mem_ret_valid),
    .mem_ret_data(mem_ret_data),
    .mem_wreq(mem_wreq), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wrdy(mem_wrdy),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_load;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  logic [127:0] mem_model [logic [27:0]];
  logic [31:0]  ref_w [logic [29:0]];
  logic [27:0]  line_of [int];

  int n_checks = 0;
  int n_fail = 0;
  int exp_hit = 0;
  int exp_miss = 0;
  int rd_hs = 0;
  int wr_hs = 0;
  int resp_cnt = 0;
  logic [31:0] last_raddr = '0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_load = '0;

  int wr_delay = 0;
  int beat_gap = 0;
  int stray_req = 0;
  int stray_done = 0;
  logic abort_beats = 1'b0;
  int abort_done = 0;

  function automatic logic [31:0] pat(input logic [29:0] wa);
    return {2'b10, wa} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [127:0] get_line(input logic [27:0] la);
    logic [127:0] l;
    if (mem_model.exists(la)) return mem_model[la];
    for (int w = 0; w < 4; w++)
      l[w*32 +: 32] = pat({la, 2'(w)});
    return l;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [127:0] l;
    if (ref_w.exists(a[31:2])) return ref_w[a[31:2]];
    l = get_line(a[31:4]);
    return l[int'(a[3:2])*32 +: 32];
  endfunction

  function automatic logic [127:0] ref_line(input logic [31:0] a);
    logic [127:0] l;
    for (int w = 0; w < 4; w++)
      l[w*32 +: 32] = ref_read({a[31:4], 2'(w), 2'b00});
    return l;
  endfunction

  function automatic int cnt_exp(input int v);
`ifdef DCACHE_PERF_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  // Memory responder: writebacks, refills, stray beats
  initial begin
    logic [127:0] l;
    int nb;
    mem_rrdy = 1'b0;
    mem_wrdy = 1'b0;
    mem_ret_valid = 1'b0;
    mem_ret_data = '0;
    mem_model[28'h4] = {32'h44, 32'h33, 32'h22, 32'h11};
    forever begin
      @(posedge clk); #1;
      if (stray_done < stray_req) begin
        mem_ret_valid = 1'b1;
        mem_ret_data = 32'hBAD0_0000 + 32'(stray_done);
        @(posedge clk); #1;
        mem_ret_valid = 1'b0;
        stray_done++;
      end else if (mem_wreq && !rst) begin
        repeat (wr_delay) begin @(posedge clk); #1; end
        mem_model[mem_waddr[31:4]] = mem_wdata;
        mem_wrdy = 1'b1;
        @(posedge clk); #1;
        mem_wrdy = 1'b0;
      end else if (mem_rreq && !rst) begin
        l = get_line(mem_raddr[31:4]);
        mem_rrdy = 1'b1;
        @(posedge clk); #1;
        mem_rrdy = 1'b0;
        nb = abort_beats ? 2 : 4;
        for (int b = 0; b < nb; b++) begin
          repeat (beat_gap) begin @(posedge clk); #1; end
          mem_ret_valid = 1'b1;
          mem_ret_data = l[b*32 +: 32];
          @(posedge clk); #1;
          mem_ret_valid = 1'b0;
        end
        if (abort_beats) abort_done++;
      end
    end
  end

  // Handshake and response monitor
  always @(negedge clk) begin
    if (mem_rreq && mem_rrdy) begin
      rd_hs <= rd_hs + 1;
      last_raddr <= mem_raddr;
    end
    if (mem_wreq && mem_wrdy) begin
      wr_hs <= wr_hs + 1;
      last_waddr <= mem_waddr;
    end
    if (cpu_resp_valid) resp_cnt <= resp_cnt + 1;
  end

  task automatic cpu_access(input logic wr, input logic [31:0] a,
                            input logic [31:0] d);
    logic hit;
    int idx;
    int lat;
    int rd0;
    logic got;
    exp_t e;
    idx = int'(a[9:4]);
    hit = line_of.exists(idx) && line_of[idx] == a[31:4];
    line_of[idx] = a[31:4];
    if (hit) exp_hit++;
    else exp_miss++;
    if (wr) begin
      ref_w[a[31:2]] = d;
      exp_q.push_back({1'b0, 32'h0});
    end else begin
      exp_q.push_back({1'b1, ref_read(a)});
    end
    rd0 = rd_hs;
    @(posedge clk); #1;
    n_checks++;
    if (cpu_ready !== 1'b1)
      $display("FAIL ready_idle addr=%h got=%b want=1", a, cpu_ready);
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    got = 1'b0;
    for (lat = 1; lat <= 400; lat++) begin
      @(negedge clk);
      if (cpu_resp_valid) begin got = 1'b1; break; end
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL resp_timeout addr=%h got=none want=resp", a);
      exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      if (e.is_load) begin
        n_checks++;
        if (cpu_rdata !== e.data) begin
          n_fail++;
          $display("FAIL rdata addr=%h got=%h want=%h",
                   a, cpu_rdata, e.data);
        end
        last_load = e.data;
      end
      if (hit && lat != 1) begin
        n_fail++;
        $display("FAIL hit_latency addr=%h got=%0d want=1", a, lat);
      end else if (!hit && lat <= 1) begin
        n_fail++;
        $display("FAIL miss_latency addr=%h got=%0d want>1", a, lat);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (rd_hs - rd0 != (hit ? 0 : 1)) begin
      n_fail++;
      $display("FAIL refill_count addr=%h got=%0d want=%0d",
               a, rd_hs - rd0, hit ? 0 : 1);
    end
    n_checks++;
    if (cpu_rdata !== last_load) begin
      n_fail++;
      $display("FAIL rdata_hold addr=%h got=%h want=%h",
               a, cpu_rdata, last_load);
    end
    n_checks++;
    if (hit_cnt !== 32'(cnt_exp(exp_hit))
        || miss_cnt !== 32'(cnt_exp(exp_miss))) begin
      n_fail++;
      $display("FAIL perf_cnt addr=%h got=%0d/%0d want=%0d/%0d", a,
               hit_cnt, miss_cnt, cnt_exp(exp_hit), cnt_exp(exp_miss));
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    n_checks++;
    if (cpu_ready !== 1'b1 || cpu_resp_valid !== 1'b0
        || cpu_rdata !== 32'h0 || mem_rreq !== 1'b0
        || mem_wreq !== 1'b0 || hit_cnt !== 32'h0
        || miss_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL %s got=%b%b_%h_%b%b_%h_%h want=10_0_00_0_0", tag,
               cpu_ready, cpu_resp_valid, cpu_rdata, mem_rreq,
               mem_wreq, hit_cnt, miss_cnt);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ref_w.delete();
    line_of.delete();
    exp_q.delete();
    exp_hit = 0;
    exp_miss = 0;
    last_load = '0;
  endtask

  task automatic test_reset();
    do_reset();
    check_idle("reset_state");
  endtask

  task automatic test_refill_load();
    cpu_access(1'b0, 32'h0000_0040, 32'h0);
    n_checks++;
    if (last_raddr !== 32'h40) begin
      n_fail++;
      $display("FAIL refill_addr got=%h want=%h", last_raddr, 32'h40);
    end
  endtask

  task automatic test_hit();
    cpu_access(1'b0, 32'h4C, 32'h0);
    cpu_access(1'b1, 32'h48, 32'hDEAD_BEEF);
    cpu_access(1'b0, 32'h48, 32'h0);
    cpu_access(1'b0, 32'h43, 32'h0);
  endtask

  task automatic test_writeback();
    logic seen;
    int wr0;
    wr0 = wr_hs;
    wr_delay = 5;
    fork
      cpu_access(1'b0, 32'h440, 32'h0);
      begin
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
          @(negedge clk);
          seen = mem_wreq;
        end
        n_checks++;
        if (!seen) begin
          n_fail++;
          $display("FAIL wb_start got=none want=mem_wreq");
        end else begin
          for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (mem_wreq !== 1'b1 || mem_waddr !== 32'h40
                || mem_wdata !== {32'h44, 32'hDEAD_BEEF,
                                  32'h22, 32'h11}) begin
              n_fail++;
              $display("FAIL wb_stable cyc=%0d got=%b_%h_%h", i,
                       mem_wreq, mem_waddr, mem_wdata);
            end
            @(negedge clk);
          end
        end
      end
    join
    wr_delay = 0;
    n_checks++;
    if (wr_hs - wr0 != 1 || last_raddr !== 32'h440) begin
      n_fail++;
      $display("FAIL wb_then_refill got=%0d_%h want=1_%h",
               wr_hs - wr0, last_raddr, 32'h440);
    end
  endtask

  task automatic test_store_miss();
    logic [127:0] l;
    int wr0;
    cpu_access(1'b1, 32'h84, 32'hCAFE_F00D);
    cpu_access(1'b0, 32'h84, 32'h0);
    wr0 = wr_hs;
    cpu_access(1'b0, 32'h884, 32'h0);
    l = mem_model[28'h8];
    n_checks++;
    if (wr_hs - wr0 != 1 || last_waddr !== 32'h80
        || l !== ref_line(32'h80) || l[63:32] !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL merged_wb got=%0d_%h_%h want=1_%h_%h",
               wr_hs - wr0, last_waddr, l, 32'h80, ref_line(32'h80));
    end
  endtask

  task automatic test_reset_abort();
    int ad0;
    int r0;
    logic done;
    ad0 = abort_done;
    abort_beats = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h1C0;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = (abort_done != ad0);
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL abort_beats got=none want=2_beats");
    end
    do_reset();
    abort_beats = 1'b0;
    check_idle("abort_reset");
    r0 = resp_cnt;
    stray_req = stray_req + 2;
    for (int i = 0; i < 50 && stray_done != stray_req; i++)
      @(negedge clk);
    check_idle("abort_stray");
    n_checks++;
    if (resp_cnt != r0 || stray_done != stray_req) begin
      n_fail++;
      $display("FAIL abort_stray_resp got=%0d want=%0d",
               resp_cnt - r0, 0);
    end
    cpu_access(1'b0, 32'h1C0, 32'h0);
  endtask

  task automatic test_gap_stray();
    int r0;
    int h0;
    int m0;
    r0 = resp_cnt;
    h0 = hit_cnt;
    m0 = miss_cnt;
    stray_req = stray_req + 3;
    for (int i = 0; i < 50 && stray_done != stray_req; i++)
      @(negedge clk);
    n_checks++;
    if (resp_cnt != r0 || hit_cnt != 32'(h0)
        || miss_cnt != 32'(m0) || cpu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_stray got=%0d_%0d_%0d_%b want=0_%0d_%0d_1",
               resp_cnt - r0, hit_cnt, miss_cnt, cpu_ready, h0, m0);
    end
    beat_gap = 3;
    cpu_access(1'b0, 32'h2C8, 32'h0);
    cpu_access(1'b0, 32'h2C0, 32'h0);
    cpu_access(1'b1, 32'h6CC, 32'h1234_5678);
    cpu_access(1'b0, 32'h6CC, 32'h0);
    beat_gap = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] pool [6];
    logic [31:0] a;
    pool[0] = 32'h040; pool[1] = 32'h440; pool[2] = 32'h080;
    pool[3] = 32'h880; pool[4] = 32'h0C0; pool[5] = 32'hC40;
    for (int i = 0; i < 30; i++) begin
      a = pool[$urandom_range(0, 5)] | {$urandom_range(0, 3), 2'b00};
      wr_delay = $urandom_range(0, 2);
      beat_gap = $urandom_range(0, 1);
      cpu_access($urandom_range(0, 1) == 1, a, $urandom);
    end
    for (int i = 0; i < 6; i++)
      cpu_access(1'b0, pool[i] | 32'h4, 32'h0);
    wr_delay = 0;
    beat_gap = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0;
    cpu_wr = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    test_reset();
    test_refill_load();
    test_hit();
    test_writeback();
    test_store_miss();
    test_reset_abort();
    test_gap_stray();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
